// File: rtl/hazard3_trigger_unit_pkg.sv
// Shared definitions for the Hazard3 trigger unit: CSR addresses, tdata1
// field positions, match encodings and the per-trigger configuration record.
package hazard3_trigger_unit_pkg;

  localparam logic [11:0] CSR_TSELECT = 12'h7a0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7a1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7a2;
  localparam logic [11:0] CSR_TINFO   = 12'h7a4;

  localparam int unsigned TD1_TYPE_LO   = 28;
  localparam int unsigned TD1_DMODE     = 27;
  localparam int unsigned TD1_HIT       = 20;
  localparam int unsigned TD1_ACTION_LO = 12;
  localparam int unsigned TD1_CHAIN     = 11;
  localparam int unsigned TD1_MATCH_LO  = 7;
  localparam int unsigned TD1_M         = 6;
  localparam int unsigned TD1_U         = 3;
  localparam int unsigned TD1_EXECUTE   = 2;
  localparam int unsigned TD1_STORE     = 1;
  localparam int unsigned TD1_LOAD      = 0;

  localparam logic [3:0]  TDATA1_TYPE_MCONTROL = 4'd2;
  localparam logic [31:0] TINFO_VALUE          = 32'h0000_0004;

  typedef enum logic [1:0] {
    MATCH_EXACT = 2'd0,
    MATCH_NAPOT = 2'd1,
    MATCH_GE    = 2'd2,
    MATCH_LT    = 2'd3
  } match_e;

  // Implemented mcontrol state for one trigger.
  typedef struct packed {
    logic   dmode;
    logic   action;
    logic   hit;
    logic   chain;
    match_e match;
    logic   m;
    logic   u;
    logic   execute;
    logic   store;
    logic   load;
  } trig_cfg_t;

  // Legalise a written 4-bit match field; unsupported encodings become exact.
  function automatic match_e match_warl(input logic [3:0] wval, input bit napot_en);
    match_e r;
    r = MATCH_EXACT;
    case (wval)
      4'd1:    r = napot_en ? MATCH_NAPOT : MATCH_EXACT;
      4'd2:    r = MATCH_GE;
      4'd3:    r = MATCH_LT;
      default: r = MATCH_EXACT;
    endcase
    return r;
  endfunction

  // Build the 32-bit tdata1 read image; unimplemented fields read zero.
  function automatic logic [31:0] tdata1_pack(input trig_cfg_t c);
    logic [31:0] r;
    r = '0;
    r[TD1_TYPE_LO +: 4]  = TDATA1_TYPE_MCONTROL;
    r[TD1_DMODE]         = c.dmode;
    r[TD1_HIT]           = c.hit;
    r[TD1_ACTION_LO]     = c.action;
    r[TD1_CHAIN]         = c.chain;
    r[TD1_MATCH_LO +: 2] = c.match;
    r[TD1_M]             = c.m;
    r[TD1_U]             = c.u;
    r[TD1_EXECUTE]       = c.execute;
    r[TD1_STORE]         = c.store;
    r[TD1_LOAD]          = c.load;
    return r;
  endfunction

endpackage

// File: rtl/hazard3_trigger_match.sv
// Address comparator for one trigger.
//   addr    : address under test (pc or load/store address)
//   tdata2  : trigger compare value
//   mode    : exact / NAPOT / ge / lt
//   match_c : combinational compare result
module hazard3_trigger_match
  import hazard3_trigger_unit_pkg::*;
#(
  parameter int unsigned W_ADDR       = 32,
  parameter int unsigned ENABLE_NAPOT = 1
) (
  input  logic [W_ADDR-1:0] addr,
  input  logic [W_ADDR-1:0] tdata2,
  input  match_e            mode,
  output logic              match_c
);

  // Trailing ones of tdata2 plus the first zero form the don't-care mask.
  logic [W_ADDR-1:0] napot_mask;
  assign napot_mask = tdata2 ^ (tdata2 + W_ADDR'(1));

  always_comb begin
    match_c = 1'b0;
    case (mode)
      MATCH_EXACT: match_c = (addr == tdata2);
      MATCH_NAPOT: match_c = (ENABLE_NAPOT != 0) && (((addr ^ tdata2) & ~napot_mask) == '0);
      MATCH_GE:    match_c = (addr >= tdata2);
      MATCH_LT:    match_c = (addr < tdata2);
      default:     match_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard3_trigger_unit.sv
// Debug trigger unit: N_TRIGGERS mcontrol address/data triggers with CSR
// access, optional NAPOT matching and chaining, and break request outputs.
//   clk, rst_n                     : clock, async active-low reset
//   cfg_addr/cfg_wen/cfg_wdata     : CSR write port; cfg_rdata is a combinational read
//   trig_m_en, m_mode, d_mode      : enables and current privilege
//   pc/pc_valid                    : execute-match input
//   ls_addr/ls_valid/ls_write      : load/store-match input
//   break_taken                    : core accepted the break this cycle
//   break_any/break_d_mode/break_is_ls : combinational break request
module hazard3_trigger_unit
  import hazard3_trigger_unit_pkg::*;
#(
  parameter int unsigned N_TRIGGERS   = 4,
  parameter int unsigned W_ADDR       = 32,
  parameter int unsigned W_DATA       = 32,
  parameter int unsigned ENABLE_NAPOT = 1,
  parameter int unsigned ENABLE_CHAIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       cfg_addr,
  input  logic              cfg_wen,
  input  logic [W_DATA-1:0] cfg_wdata,
  output logic [W_DATA-1:0] cfg_rdata,
  input  logic              trig_m_en,
  input  logic              m_mode,
  input  logic              d_mode,
  input  logic [W_ADDR-1:0] pc,
  input  logic              pc_valid,
  input  logic [W_ADDR-1:0] ls_addr,
  input  logic              ls_valid,
  input  logic              ls_write,
  input  logic              break_taken,
  output logic              break_any,
  output logic              break_d_mode,
  output logic              break_is_ls
);

  localparam int unsigned W_TSEL = (N_TRIGGERS > 1) ? $clog2(N_TRIGGERS) : 1;

  logic [W_TSEL-1:0] tselect;
  trig_cfg_t         cfg    [N_TRIGGERS];
  logic [W_ADDR-1:0] tdata2 [N_TRIGGERS];

  trig_cfg_t sel_cfg;
  trig_cfg_t wr_cfg;
  logic      sel_locked;
  logic      sel_is_last;
  logic      wr_dmode;

  logic [N_TRIGGERS-1:0] pc_hit;
  logic [N_TRIGGERS-1:0] ls_hit;
  logic [N_TRIGGERS-1:0] priv_ok;
  logic [N_TRIGGERS-1:0] exec_match;
  logic [N_TRIGGERS-1:0] ls_match;
  logic [N_TRIGGERS-1:0] any_match;
  logic [N_TRIGGERS-1:0] chain_eff;
  logic [N_TRIGGERS-1:0] fire;
  logic [N_TRIGGERS-1:0] in_fired;

  logic chain_ok;
  logic hit_run;
  logic found_d;
  logic found_m;
  logic ls_d;
  logic ls_m;

  assign sel_cfg     = cfg[tselect];
  // A D-mode-owned trigger is read-only while the core is outside Debug Mode.
  assign sel_locked  = sel_cfg.dmode && !d_mode;
  assign sel_is_last = (32'(tselect) == N_TRIGGERS - 1);

  // Legalised tdata1 write value for the selected trigger.
  always_comb begin
    wr_cfg         = '0;
    wr_dmode       = d_mode && cfg_wdata[TD1_DMODE];
    wr_cfg.dmode   = wr_dmode;
    wr_cfg.action  = wr_dmode && (cfg_wdata[TD1_ACTION_LO +: 4] == 4'd1);
    wr_cfg.hit     = cfg_wdata[TD1_HIT];
    wr_cfg.chain   = (ENABLE_CHAIN != 0) && !sel_is_last && cfg_wdata[TD1_CHAIN];
    wr_cfg.match   = match_warl(cfg_wdata[TD1_MATCH_LO +: 4], ENABLE_NAPOT != 0);
    wr_cfg.m       = cfg_wdata[TD1_M];
    wr_cfg.u       = cfg_wdata[TD1_U];
    wr_cfg.execute = cfg_wdata[TD1_EXECUTE];
    wr_cfg.store   = cfg_wdata[TD1_STORE];
    wr_cfg.load    = cfg_wdata[TD1_LOAD];
  end

  // CSR read mux.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CSR_TSELECT: cfg_rdata = W_DATA'(tselect);
      CSR_TDATA1:  cfg_rdata = W_DATA'(tdata1_pack(sel_cfg));
      CSR_TDATA2:  cfg_rdata = W_DATA'(tdata2[tselect]);
      CSR_TINFO:   cfg_rdata = W_DATA'(TINFO_VALUE);
      default:     cfg_rdata = '0;
    endcase
  end

  // Per-trigger comparators and match qualification.
  for (genvar i = 0; i < int'(N_TRIGGERS); i++) begin : g_trig
    localparam bit CAN_CHAIN = (ENABLE_CHAIN != 0) && (32'(i) + 1 < N_TRIGGERS);

    hazard3_trigger_match #(
      .W_ADDR       (W_ADDR),
      .ENABLE_NAPOT (ENABLE_NAPOT)
    ) u_match_pc (
      .addr    (pc),
      .tdata2  (tdata2[i]),
      .mode    (cfg[i].match),
      .match_c (pc_hit[i])
    );

    hazard3_trigger_match #(
      .W_ADDR       (W_ADDR),
      .ENABLE_NAPOT (ENABLE_NAPOT)
    ) u_match_ls (
      .addr    (ls_addr),
      .tdata2  (tdata2[i]),
      .mode    (cfg[i].match),
      .match_c (ls_hit[i])
    );

    assign priv_ok[i]    = !d_mode && (m_mode ? cfg[i].m : cfg[i].u);
    assign exec_match[i] = cfg[i].execute && pc_valid && pc_hit[i] && priv_ok[i];
    assign ls_match[i]   = ls_valid && (ls_write ? cfg[i].store : cfg[i].load)
                           && ls_hit[i] && priv_ok[i];
    assign any_match[i]  = exec_match[i] || ls_match[i];
    assign chain_eff[i]  = CAN_CHAIN && cfg[i].chain;
  end

  // Chain resolution, hit marking and break arbitration (D-mode beats M-mode,
  // then lowest index). Only the last member of a chain can fire.
  always_comb begin
    fire         = '0;
    in_fired     = '0;
    chain_ok     = 1'b1;
    hit_run      = 1'b0;
    found_d      = 1'b0;
    found_m      = 1'b0;
    ls_d         = 1'b0;
    ls_m         = 1'b0;
    for (int i = 0; i < int'(N_TRIGGERS); i++) begin
      chain_ok = chain_ok && any_match[i];
      if (!chain_eff[i]) begin
        fire[i]  = chain_ok && (cfg[i].action ? cfg[i].dmode : trig_m_en);
        chain_ok = 1'b1;
      end
    end
    // Walk backwards so every chain member inherits its chain's fire.
    for (int i = int'(N_TRIGGERS) - 1; i >= 0; i--) begin
      if (!chain_eff[i]) begin
        hit_run = fire[i];
      end
      in_fired[i] = hit_run;
    end
    for (int i = 0; i < int'(N_TRIGGERS); i++) begin
      if (fire[i]) begin
        if (cfg[i].action) begin
          if (!found_d) begin
            found_d = 1'b1;
            ls_d    = !exec_match[i];
          end
        end else if (!found_m) begin
          found_m = 1'b1;
          ls_m    = !exec_match[i];
        end
      end
    end
    break_any    = |fire;
    break_d_mode = found_d;
    break_is_ls  = found_d ? ls_d : ls_m;
  end

  // CSR state; a same-cycle tdata1 write overrides hit setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tselect <= '0;
      for (int i = 0; i < int'(N_TRIGGERS); i++) begin
        cfg[i]    <= '0;
        tdata2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_TRIGGERS); i++) begin
        if (break_taken && in_fired[i]) begin
          cfg[i].hit <= 1'b1;
        end
      end
      if (cfg_wen) begin
        case (cfg_addr)
          CSR_TSELECT: begin
            if (cfg_wdata < W_DATA'(N_TRIGGERS)) begin
              tselect <= W_TSEL'(cfg_wdata);
            end
          end
          CSR_TDATA1: begin
            if (!sel_locked) begin
              cfg[tselect] <= wr_cfg;
            end
          end
          CSR_TDATA2: begin
            if (!sel_locked) begin
              tdata2[tselect] <= W_ADDR'(cfg_wdata);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard3_trigger_unit.sv
// Directed self-checking bench for hazard3_trigger_unit (default parameters).
module tb_hazard3_trigger_unit;

  localparam logic [11:0] A_TSELECT = 12'h7a0;
  localparam logic [11:0] A_TDATA1  = 12'h7a1;
  localparam logic [11:0] A_TDATA2  = 12'h7a2;
  localparam logic [11:0] A_TINFO   = 12'h7a4;

  logic        clk;
  logic        rst_n;
  logic [11:0] cfg_addr;
  logic        cfg_wen;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        trig_m_en;
  logic        m_mode;
  logic        d_mode;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] ls_addr;
  logic        ls_valid;
  logic        ls_write;
  logic        break_taken;
  logic        break_any;
  logic        break_d_mode;
  logic        break_is_ls;

  int n_checks;
  int n_errors;

  hazard3_trigger_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_addr     (cfg_addr),
    .cfg_wen      (cfg_wen),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .trig_m_en    (trig_m_en),
    .m_mode       (m_mode),
    .d_mode       (d_mode),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .ls_addr      (ls_addr),
    .ls_valid     (ls_valid),
    .ls_write     (ls_write),
    .break_taken  (break_taken),
    .break_any    (break_any),
    .break_d_mode (break_d_mode),
    .break_is_ls  (break_is_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wen   = 1'b1;
    @(negedge clk);
    cfg_wen   = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic brk_chk(input string tag, input logic any, input logic dm, input logic ls);
    #1;
    check({tag, "_any"}, 32'(break_any), 32'(any));
    check({tag, "_dm"},  32'(break_d_mode), 32'(dm));
    check({tag, "_ls"},  32'(break_is_ls), 32'(ls));
  endtask

  task automatic set_pc(input logic [31:0] a, input logic v);
    @(negedge clk);
    pc       = a;
    pc_valid = v;
  endtask

  task automatic set_ls(input logic [31:0] a, input logic v, input logic w);
    @(negedge clk);
    ls_addr  = a;
    ls_valid = v;
    ls_write = w;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    cfg_addr    = A_TSELECT;
    cfg_wen     = 1'b0;
    cfg_wdata   = '0;
    trig_m_en   = 1'b0;
    m_mode      = 1'b1;
    d_mode      = 1'b0;
    pc          = '0;
    pc_valid    = 1'b0;
    ls_addr     = '0;
    ls_valid    = 1'b0;
    ls_write    = 1'b0;
    break_taken = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    brk_chk("rst", 1'b0, 1'b0, 1'b0);
    csr_chk("rst_tselect", A_TSELECT, 32'h0);
    csr_chk("rst_tdata1", A_TDATA1, 32'h2000_0000);
    csr_chk("rst_tdata2", A_TDATA2, 32'h0);
    csr_chk("tinfo", A_TINFO, 32'h0000_0004);
    @(negedge clk);
    rst_n = 1'b1;

    // T0: exact execute match in M-mode
    csr_wr(A_TSELECT, 32'd0);
    csr_wr(A_TDATA2, 32'h100);
    csr_wr(A_TDATA1, 32'h0000_0044);
    csr_chk("t0_tdata1", A_TDATA1, 32'h2000_0044);
    csr_chk("t0_tdata2", A_TDATA2, 32'h0000_0100);
    trig_m_en = 1'b1;
    set_pc(32'h100, 1'b1);
    brk_chk("t0_hit", 1'b1, 1'b0, 1'b0);
    set_pc(32'h104, 1'b1);
    brk_chk("t0_other_pc", 1'b0, 1'b0, 1'b0);
    set_pc(32'h100, 1'b0);
    brk_chk("t0_pc_invalid", 1'b0, 1'b0, 1'b0);
    set_pc(32'h100, 1'b1);
    trig_m_en = 1'b0;
    brk_chk("t0_m_en_off", 1'b0, 1'b0, 1'b0);
    trig_m_en = 1'b1;
    d_mode = 1'b1;
    brk_chk("t0_in_dmode", 1'b0, 1'b0, 1'b0);
    d_mode = 1'b0;
    m_mode = 1'b0;
    brk_chk("t0_umode", 1'b0, 1'b0, 1'b0);
    csr_wr(A_TDATA1, 32'h0);
    set_pc(32'h0, 1'b0);

    // T1: NAPOT load match in U-mode. 0x2007 has three trailing ones, so
    // the window is 0x2000-0x200f; 0x2003 gives the 8-byte window 0x2000-0x2007.
    csr_wr(A_TSELECT, 32'd1);
    csr_wr(A_TDATA2, 32'h2007);
    csr_wr(A_TDATA1, 32'h0000_0089);
    csr_chk("t1_tdata1", A_TDATA1, 32'h2000_0089);
    set_ls(32'h2004, 1'b1, 1'b0);
    brk_chk("napot_in", 1'b1, 1'b0, 1'b1);
    set_ls(32'h2010, 1'b1, 1'b0);
    brk_chk("napot_above", 1'b0, 1'b0, 1'b0);
    set_ls(32'h1fff, 1'b1, 1'b0);
    brk_chk("napot_below", 1'b0, 1'b0, 1'b0);
    set_ls(32'h2004, 1'b1, 1'b1);
    brk_chk("napot_store", 1'b0, 1'b0, 1'b0);
    csr_wr(A_TDATA2, 32'h2003);
    set_ls(32'h2004, 1'b1, 1'b0);
    brk_chk("napot8_in", 1'b1, 1'b0, 1'b1);
    set_ls(32'h2008, 1'b1, 1'b0);
    brk_chk("napot8_out", 1'b0, 1'b0, 1'b0);
    set_ls(32'h0, 1'b0, 1'b0);
    m_mode = 1'b1;

    // WARL legalisation
    csr_wr(A_TDATA1, 32'h0000_0280);
    csr_chk("warl_match", A_TDATA1, 32'h2000_0000);
    csr_wr(A_TDATA1, 32'h0800_1004);
    csr_chk("warl_dmode_action", A_TDATA1, 32'h2000_0004);
    csr_wr(A_TSELECT, 32'd3);
    csr_wr(A_TDATA1, 32'h0000_0800);
    csr_chk("warl_last_chain", A_TDATA1, 32'h2000_0000);
    csr_wr(A_TSELECT, 32'd2);
    csr_wr(A_TDATA1, 32'h0000_0800);
    csr_chk("chain_writable", A_TDATA1, 32'h2000_0800);
    csr_wr(A_TDATA1, 32'h0);

    // Chain T0 (ge 0x1000) -> T1 (lt 0x2000, D-mode action), programmed in D-mode
    d_mode = 1'b1;
    csr_wr(A_TSELECT, 32'd0);
    csr_wr(A_TDATA2, 32'h1000);
    csr_wr(A_TDATA1, 32'h0000_0944);
    csr_wr(A_TSELECT, 32'd1);
    csr_wr(A_TDATA2, 32'h2000);
    csr_wr(A_TDATA1, 32'h0800_11c4);
    csr_chk("t1_dmode_rd", A_TDATA1, 32'h2800_11c4);
    csr_wr(A_TSELECT, 32'd2);
    csr_wr(A_TDATA2, 32'h3000);
    csr_wr(A_TDATA1, 32'h0000_0041);
    d_mode = 1'b0;
    trig_m_en = 1'b0;
    set_pc(32'h1800, 1'b1);
    brk_chk("chain_in", 1'b1, 1'b1, 1'b0);
    set_pc(32'h2800, 1'b1);
    brk_chk("chain_t1_miss", 1'b0, 1'b0, 1'b0);
    set_pc(32'h0800, 1'b1);
    brk_chk("chain_t0_miss", 1'b0, 1'b0, 1'b0);
    set_pc(32'h1000, 1'b1);
    brk_chk("chain_ge_edge", 1'b1, 1'b1, 1'b0);
    set_pc(32'h2000, 1'b1);
    brk_chk("chain_lt_edge", 1'b0, 1'b0, 1'b0);

    // D-mode fire outranks a simultaneous M-mode load fire on T2
    trig_m_en = 1'b1;
    set_pc(32'h1800, 1'b1);
    set_ls(32'h3000, 1'b1, 1'b0);
    brk_chk("prio_both", 1'b1, 1'b1, 1'b0);
    set_pc(32'h1800, 1'b0);
    brk_chk("prio_m_only", 1'b1, 1'b0, 1'b1);
    set_ls(32'h0, 1'b0, 1'b0);

    // break_taken marks every member of the fired chain
    set_pc(32'h1800, 1'b1);
    break_taken = 1'b1;
    @(negedge clk);
    break_taken = 1'b0;
    csr_wr(A_TSELECT, 32'd0);
    csr_chk("hit_t0", A_TDATA1, 32'h2010_0944);
    csr_wr(A_TSELECT, 32'd1);
    csr_chk("hit_t1", A_TDATA1, 32'h2810_11c4);
    csr_wr(A_TSELECT, 32'd2);
    csr_chk("hit_t2_clear", A_TDATA1, 32'h2000_0041);

    // Protection of D-mode triggers and tselect range
    csr_wr(A_TSELECT, 32'd1);
    csr_wr(A_TDATA2, 32'h5555);
    csr_chk("locked_tdata2", A_TDATA2, 32'h0000_2000);
    csr_wr(A_TDATA1, 32'h0);
    csr_chk("locked_tdata1", A_TDATA1, 32'h2810_11c4);
    csr_wr(A_TSELECT, 32'd4);
    csr_chk("tselect_range", A_TSELECT, 32'd1);

    // Same-cycle hit set and tdata1 write: the write value is kept
    csr_wr(A_TSELECT, 32'd0);
    @(negedge clk);
    break_taken = 1'b1;
    cfg_addr    = A_TDATA1;
    cfg_wdata   = 32'h0000_0944;
    cfg_wen     = 1'b1;
    @(negedge clk);
    break_taken = 1'b0;
    cfg_wen     = 1'b0;
    csr_chk("write_beats_hit", A_TDATA1, 32'h2000_0944);

    // Asynchronous reset while a break is requested
    set_pc(32'h1800, 1'b1);
    brk_chk("pre_reset", 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    brk_chk("async_reset", 1'b0, 1'b0, 1'b0);
    csr_chk("reset_tselect", A_TSELECT, 32'h0);
    csr_chk("reset_tdata1", A_TDATA1, 32'h2000_0000);
    csr_chk("reset_tdata2", A_TDATA2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
